celc_chain_meter: RTL and testbench



---
 rtl/celc_chain_meter.sv | 133 +++++++++++++
 tb/tb_celc_chain_meter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/celc_chain_meter.sv
// Launch/capture controller for a C-element delay chain. It toggles chain_in and counts cycles until the edge returns.
// Optional CELC_METER_AVG_EN: each start runs four alternating-polarity measurements and reports their floored mean.
module celc_chain_meter #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 chain_out,
  output logic                 chain_in,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_ref;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_sync_q;
  logic                 w_arrived;
  logic                 w_run_to;
  logic [CNT_WIDTH-1:0] w_run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], chain_out};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  // Arrival is any departure from the level captured at launch, so chain inversion does not matter.
  always_comb begin
    w_arrived = (w_sync_q != r_ref);
    w_run_to  = !w_arrived && (r_cnt == '1);
    w_run_cnt = w_arrived ? r_cnt + CNT_WIDTH'(1) : '1;
  end

`ifdef CELC_METER_AVG_EN
  logic [1:0]           r_run;
  logic [CNT_WIDTH+1:0] r_acc;
  logic                 r_to_any;
  logic [CNT_WIDTH+1:0] w_acc_next;
  logic                 w_to_any_next;

  always_comb begin
    w_acc_next    = r_acc + {2'b00, w_run_cnt};
    w_to_any_next = r_to_any | w_run_to;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ref    <= 1'b0;
      r_cnt    <= '0;
      chain_in <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      count    <= '0;
`ifdef CELC_METER_AVG_EN
      r_run    <= '0;
      r_acc    <= '0;
      r_to_any <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            chain_in <= ~chain_in;
            r_ref    <= w_sync_q;
            r_cnt    <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_WAIT;
`ifdef CELC_METER_AVG_EN
            r_run    <= '0;
            r_acc    <= '0;
            r_to_any <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (w_arrived || w_run_to) begin
`ifdef CELC_METER_AVG_EN
            if (r_run == 2'd3) begin
              count   <= w_acc_next[CNT_WIDTH+1:2];
              timeout <= w_to_any_next;
              done    <= 1'b1;
              r_state <= S_FIN;
            end else begin
              // Relaunch on the arrival edge itself: sync_q already shows the settled level to use as ref.
              chain_in <= ~chain_in;
              r_ref    <= w_sync_q;
              r_cnt    <= '0;
              r_run    <= r_run + 2'd1;
              r_acc    <= w_acc_next;
              r_to_any <= w_to_any_next;
            end
`else
            count   <= w_run_cnt;
            timeout <= w_run_to;
            done    <= 1'b1;
            r_state <= S_FIN;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_celc_chain_meter.sv
// Bench for celc_chain_meter: two instances (16-bit and 4-bit counters) driving delayed-copy chain models.
`timescale 1ns/1ps
module tb_celc_chain_meter;

  localparam int SYNC = 2;
`ifdef CELC_METER_AVG_EN
  localparam int NR = 4;
`else
  localparam int NR = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  bit   tied  [2];
  int   dtab  [2][4];
  int   tog   [2];
  int   cyc = 0;

  wire        ci    [2];
  wire        bsy   [2];
  wire        dn    [2];
  wire        to_o  [2];
  wire [15:0] cnt_o [2];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = (g == 0) ? 16 : 4;

    logic         r_dl = 1'b0;
    logic         w_co;
    logic         w_ci, w_bsy, w_dn, w_to;
    logic [W-1:0] w_cnt;

    assign w_co     = tied[g] ? 1'b0 : r_dl;
    assign ci[g]    = w_ci;
    assign bsy[g]   = w_bsy;
    assign dn[g]    = w_dn;
    assign to_o[g]  = w_to;
    assign cnt_o[g] = 16'(w_cnt);

    celc_chain_meter #(
      .CNT_WIDTH  (W),
      .SYNC_STAGES(SYNC)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .chain_out(w_co),
      .chain_in (w_ci),
      .busy     (w_bsy),
      .done     (w_dn),
      .timeout  (w_to),
      .count    (w_cnt)
    );

    // Chain: transport-delayed copy of chain_in; delay chosen per edge from dtab.
    always @(w_ci) begin
      fork
        begin
          automatic int   dd = dtab[g][tog[g] % 4];
          automatic logic vv = w_ci;
          #(dd);
          r_dl = vv;
        end
      join_none
      tog[g]++;
    end

    // Model: on acceptance, the whole measurement timeline is predicted from the chain delays.
    function automatic void predict(input int d, input bit tie, output int edges,
                                    output int cv, output bit tmo);
      int lim;
      int k;
      lim = 1 << W;
      k   = tie ? lim + 1 : d / 10 + 1 + SYNC;
      if (k <= lim) begin
        edges = k; cv = k % lim; tmo = 1'b0;
      end else begin
        edges = lim; cv = lim - 1; tmo = 1'b1;
      end
    endfunction

    int unsigned mc = 0;
    bit   act = 1'b0;
    int   fin, p_cnt, t, ed, cv, acc;
    bit   p_to, tm;
    int   relc [4];
    logic e_ci = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_to = 1'b0;
    logic [W-1:0] e_cnt = '0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        act = 1'b0; e_ci = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0; e_cnt = '0;
      end else begin
        mc++;
        if (act) begin
          for (int r = 1; r < NR; r++) if (mc == relc[r]) e_ci = ~e_ci;
          if (mc == fin) begin
            e_done = 1'b1; e_cnt = W'(p_cnt); e_to = p_to;
          end else if (mc == fin + 1) begin
            e_done = 1'b0; e_busy = 1'b0; act = 1'b0;
          end
        end else if (start[g]) begin
          act = 1'b1; e_ci = ~e_ci; e_busy = 1'b1; e_to = 1'b0;
          t = mc; acc = 0; p_to = 1'b0;
          for (int r = 0; r < NR; r++) begin
            predict(dtab[g][(tog[g] + r) % 4], tied[g], ed, cv, tm);
            relc[r] = t; t += ed; acc += cv; p_to |= tm;
          end
          fin = t; p_cnt = acc / NR;
        end
      end
    end

    always @(posedge clk) begin
      #2;
      chk($sformatf("i%0d_chain_in", g), w_ci, e_ci);
      chk($sformatf("i%0d_busy", g), w_bsy, e_busy);
      chk($sformatf("i%0d_done", g), w_dn, e_done);
      chk($sformatf("i%0d_timeout", g), w_to, e_to);
      chk($sformatf("i%0d_count", g), w_cnt, e_cnt);
    end
  end

  task automatic set_dly(input int g, input int d);
    for (int i = 0; i < 4; i++) dtab[g][i] = d;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk) start[g] = 1'b1;
    @(negedge clk) start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #2;
      if (dn[g]) begin
        at = cyc;
        return;
      end
    end
    chk($sformatf("done_wait_i%0d", g), 0, 1);
  endtask

  int c1, c2;

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    tied[0]  = 1'b0; tied[1]  = 1'b0;
    tog[0]   = 0;    tog[1]   = 0;
    set_dly(0, 1);
    set_dly(1, 31);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle without start
    repeat (100) @(negedge clk);
    chk("idle_chain_in", ci[0], 0);
    chk("idle_busy", bsy[0], 0);
    chk("idle_done", dn[0], 0);
    chk("idle_count", cnt_o[0], 0);

    // 10 periods + 1 ns, start held for two back-to-back measurements
    set_dly(0, 101);
    @(negedge clk) start[0] = 1'b1;
    wait_done(0, NR * 20 + 20, c1);
    chk("b2b_count1", cnt_o[0], 13);
    chk("b2b_chain_in1", ci[0], (NR == 1) ? 1 : 0);
    wait_done(0, NR * 20 + 20, c2);
    @(negedge clk) start[0] = 1'b0;
    chk("b2b_count2", cnt_o[0], 13);
    chk("b2b_chain_in2", ci[0], 0);
    chk("b2b_period", c2 - c1, NR * 13 + 2);

    // Reset five cycles into a 20-cycle-delay measurement
    set_dly(0, 201);
    pulse_start(0);
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bsy[0], 1);
    rst = 1'b1;
    #1;
    chk("rst_chain_in", ci[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_count", cnt_o[0], 0);
    chk("rst_timeout", to_o[0], 0);
    @(negedge clk) rst = 1'b0;
    repeat (30) @(negedge clk);
    pulse_start(0);
    wait_done(0, NR * 30 + 20, c1);
    chk("post_rst_count", cnt_o[0], 23);
    chk("post_rst_timeout", to_o[0], 0);
    chk("post_rst_chain_in", ci[0], (NR == 1) ? 1 : 0);

    // 1 ns chain: minimum count SYNC+1
    set_dly(0, 1);
    repeat (3) @(negedge clk);
    pulse_start(0);
    wait_done(0, NR * 10 + 20, c1);
    chk("min_count", cnt_o[0], 3);
    chk("min_timeout", to_o[0], 0);
    chk("min_chain_in", ci[0], 0);
    @(posedge clk);
    #2;
    chk("min_done_1cyc", dn[0], 0);
    chk("min_count_held", cnt_o[0], 3);

    // 4-bit counter, chain stuck at 0 then repaired
    tied[1] = 1'b1;
    pulse_start(1);
    wait_done(1, NR * 16 + 20, c1);
    chk("tmo_count", cnt_o[1], 15);
    chk("tmo_timeout", to_o[1], 1);
    repeat (3) @(negedge clk);
    chk("tmo_held", to_o[1], 1);
    tied[1] = 1'b0;
    repeat (10) @(negedge clk);
    pulse_start(1);
    wait_done(1, NR * 16 + 20, c1);
    chk("rec_count", cnt_o[1], 6);
    chk("rec_timeout", to_o[1], 0);

`ifdef CELC_METER_AVG_EN
    // Four runs with arrivals before E3..E6 -> counts 5,6,7,8
    repeat (3) @(negedge clk);
    tog[0] = 0;
    dtab[0][0] = 21; dtab[0][1] = 31; dtab[0][2] = 41; dtab[0][3] = 51;
    pulse_start(0);
    wait_done(0, 60, c1);
    chk("avg_count", cnt_o[0], 6);
    chk("avg_timeout", to_o[0], 0);
    @(posedge clk);
    #2;
    chk("avg_done_1cyc", dn[0], 0);
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
